// File: rtl/shader_prog_arbiter.sv
// Shares a single-port instruction memory between shader-core reads and buffered SPI loader writes.
// Writes drain in idle cycles, are forced after a starvation limit, or commit atomically at frame start.
module shader_prog_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              exec_req_i,
  input  logic [ADDR_W-1:0] exec_addr_i,
  output logic              exec_gnt_o,
  output logic              exec_rvalid_o,
  output logic [DATA_W-1:0] exec_rdata_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              sync_i,
  input  logic              commit_i,
  output logic              pending_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, drain_n, drain_n_nxt;
  logic [STV_W-1:0]  starve_cnt, starve_nxt;
  logic              push, pop, nonempty, forced, gnt;

  assign nonempty   = (count != '0);
  assign wr_ready_o = (count != CNT_W'(FIFO_DEPTH));
  assign push       = wr_valid_i & wr_ready_o;
  assign forced     = nonempty && (starve_cnt == STV_W'(STARVE_LIM));

  always_comb begin
    state_nxt   = state;
    drain_n_nxt = drain_n;
    starve_nxt  = '0;
    gnt         = 1'b0;
    pop         = 1'b0;
    case (state)
      RUN: begin
        pop = nonempty && (!exec_req_i || forced);
        gnt = exec_req_i && !forced;
        if (nonempty && !pop && (starve_cnt < STV_W'(STARVE_LIM)))
          starve_nxt = starve_cnt + STV_W'(1);
        if (sync_i)
          state_nxt = HOLD;
      end
      HOLD: begin
        gnt = exec_req_i;
        if (commit_i && nonempty) begin
          state_nxt   = DRAIN;
          drain_n_nxt = count;
        end else if (!sync_i) begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        // Only the entries counted at commit drain; late pushes wait for the next frame.
        pop         = 1'b1;
        drain_n_nxt = drain_n - CNT_W'(1);
        if (drain_n == CNT_W'(1))
          state_nxt = sync_i ? HOLD : RUN;
      end
      default: state_nxt = RUN;
    endcase
    // Memory must stay idle while reset is held, whatever the core requests.
    gnt = gnt & rst_ni;
    pop = pop & rst_ni;
  end

  assign exec_gnt_o   = gnt;
  assign mem_en_o     = gnt | pop;
  assign mem_we_o     = pop;
  assign mem_addr_o   = pop ? fifo_addr[rd_ptr] : exec_addr_i;
  assign mem_wdata_o  = fifo_data[rd_ptr];
  assign exec_rdata_o = mem_rdata_i;
  assign pending_o    = nonempty | (state == DRAIN);

  // Control state: async reset discards buffered writes and aborts a drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= RUN;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      drain_n       <= '0;
      starve_cnt    <= '0;
      exec_rvalid_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      drain_n       <= drain_n_nxt;
      starve_cnt    <= starve_nxt;
      exec_rvalid_o <= gnt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr_i;
      fifo_data[wr_ptr] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_shader_prog_arbiter.sv
// Directed bench for shader_prog_arbiter: queue-based reference model compared every cycle,
// plus hand-computed literal checks for each scenario.
module tb_shader_prog_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       exec_req, exec_gnt, exec_rvalid;
  logic [3:0] exec_addr;
  logic [7:0] exec_rdata;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sync, commit, pending;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shader_prog_arbiter #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4), .STARVE_LIM(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .exec_req_i(exec_req), .exec_addr_i(exec_addr), .exec_gnt_o(exec_gnt),
    .exec_rvalid_o(exec_rvalid), .exec_rdata_o(exec_rdata),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .sync_i(sync), .commit_i(commit), .pending_o(pending),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [7:0] init_val(int i);
    return (i == 7) ? 8'h3C : 8'(i * 16 + i);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory with 1-cycle read latency.
  logic [7:0] bmem [16];
  bit         bloaded = 1'b0;
  always @(posedge clk) begin
    if (!bloaded) begin
      for (int i = 0; i < 16; i++) bmem[i] = init_val(i);
      bloaded = 1'b1;
    end else if (mem_en && mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end else if (mem_en) begin
      mem_rdata <= bmem[mem_addr];
    end
  end

  // Reference model: write queue, mode, starvation wait, drain budget.
  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t        q[$];
  int         mode = 0;          // 0 normal, 1 held for frame, 2 committing
  int         starve = 0;
  int         drain_left = 0;
  bit         prev_gnt = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [7:0] mmem [16];
  bit         mloaded = 1'b0;

  always @(negedge clk) begin
    int  sz0;
    bit  e_wr, e_gnt, frc;
    if (!mloaded) begin
      for (int i = 0; i < 16; i++) mmem[i] = init_val(i);
      mloaded = 1'b1;
    end
    if (!rst_n) begin
      q.delete();
      mode = 0; starve = 0; drain_left = 0; prev_gnt = 1'b0;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_gnt", 32'(exec_gnt), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_rvalid", 32'(exec_rvalid), 0);
    end else begin
      sz0 = q.size();
      e_wr = 1'b0; e_gnt = 1'b0;
      frc = (sz0 > 0) && (starve == 8);
      if (mode == 0) begin
        e_wr  = (sz0 > 0) && (!exec_req || frc);
        e_gnt = exec_req && !frc;
      end else if (mode == 1) begin
        e_gnt = exec_req;
      end else begin
        e_wr = (sz0 > 0);
      end
      chk("m_gnt", 32'(exec_gnt), 32'(e_gnt));
      chk("m_mem_en", 32'(mem_en), 32'(e_gnt | e_wr));
      chk("m_mem_we", 32'(mem_we), 32'(e_wr));
      if (e_wr) begin
        chk("m_wr_addr", 32'(mem_addr), 32'(q[0].a));
        chk("m_wr_data", 32'(mem_wdata), 32'(q[0].d));
      end else if (e_gnt) begin
        chk("m_rd_addr", 32'(mem_addr), 32'(exec_addr));
      end
      chk("m_wr_ready", 32'(wr_ready), 32'(sz0 < 4));
      chk("m_pending", 32'(pending), 32'((sz0 > 0) || (mode == 2)));
      chk("m_rvalid", 32'(exec_rvalid), 32'(prev_gnt));
      if (prev_gnt) chk("m_rdata", 32'(exec_rdata), 32'(mmem[prev_addr]));
      prev_gnt  = e_gnt;
      prev_addr = exec_addr;
      if (mode == 0) begin
        starve = (sz0 == 0 || e_wr) ? 0 : ((starve < 8) ? starve + 1 : 8);
        if (sync) mode = 1;
      end else if (mode == 1) begin
        starve = 0;
        if (commit && sz0 > 0) begin mode = 2; drain_left = sz0; end
        else if (!sync) mode = 0;
      end else begin
        starve = 0;
        drain_left--;
        if (drain_left == 0) mode = sync ? 1 : 0;
      end
      if (e_wr) begin
        mmem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_valid && sz0 < 4) q.push_back('{a: wr_addr, d: wr_data});
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int first, zeros, nw;
    bit found;
    rst_n = 1'b0; exec_req = 1'b0; exec_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; sync = 1'b0; commit = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;

    // 1: idle load
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    mid(); nxt();
    wr_addr = 4'd4; wr_data = 8'h5A;
    mid();
    chk("t1_we0", 32'(mem_we), 1); chk("t1_addr0", 32'(mem_addr), 3); chk("t1_data0", 32'(mem_wdata), 32'hA5);
    nxt();
    wr_valid = 1'b0;
    mid();
    chk("t1_we1", 32'(mem_we), 1); chk("t1_addr1", 32'(mem_addr), 4); chk("t1_data1", 32'(mem_wdata), 32'h5A);
    chk("t1_pend_mid", 32'(pending), 1);
    nxt();
    mid(); chk("t1_pend_end", 32'(pending), 0); chk("t1_idle", 32'(mem_en), 0);
    nxt();

    // 2: exec priority read
    exec_req = 1'b1; exec_addr = 4'd7;
    mid(); chk("t2_gnt", 32'(exec_gnt), 1); chk("t2_we", 32'(mem_we), 0);
    nxt();
    mid(); chk("t2_rvalid", 32'(exec_rvalid), 1); chk("t2_rdata", 32'(exec_rdata), 32'h3C);
    nxt();

    // 3: starvation forces one write
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 8'h77;
    mid(); nxt();
    wr_valid = 1'b0;
    first = 0; zeros = 0;
    for (int k = 1; k <= 20; k++) begin
      mid();
      if (!exec_gnt) begin
        zeros++;
        if (first == 0) first = k;
        chk("t3_force_addr", 32'(mem_addr), 9);
      end
      nxt();
    end
    chk("t3_first_drop", 32'(first), 9);
    chk("t3_drop_count", 32'(zeros), 1);

    // 4: backpressure
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(8 + i); wr_data = 8'(8'hC0 + i);
      mid(); nxt();
    end
    wr_addr = 4'hE; wr_data = 8'hEE;
    mid(); chk("t4_full", 32'(wr_ready), 0);
    nxt();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      mid();
      if (wr_ready) found = 1'b1;
      nxt();
    end
    chk("t4_accepted", 32'(found), 1);
    wr_valid = 1'b0; exec_req = 1'b0;
    for (int k = 0; k < 8; k++) begin mid(); nxt(); end
    mid(); chk("t4_drained", 32'(pending), 0);
    nxt();

    // 5: sync hold and commit
    sync = 1'b1; exec_req = 1'b1; exec_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(1 + i); wr_data = 8'(8'h11 * (i + 1));
      mid(); nxt();
    end
    wr_valid = 1'b0;
    nw = 0;
    for (int k = 0; k < 20; k++) begin mid(); if (mem_we) nw++; nxt(); end
    chk("t5_held", 32'(nw), 0);
    chk("t5_pend", 32'(pending), 1);
    commit = 1'b1;
    mid(); chk("t5_commit_gnt", 32'(exec_gnt), 1);
    nxt();
    commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = (i == 1); wr_addr = 4'd5; wr_data = 8'h55;
      mid();
      chk("t5_drain_we", 32'(mem_we), 1); chk("t5_drain_gnt", 32'(exec_gnt), 0);
      chk("t5_drain_addr", 32'(mem_addr), 32'(i + 1));
      nxt();
    end
    wr_valid = 1'b0;
    mid(); chk("t5_after_we", 32'(mem_we), 0); chk("t5_late_buf", 32'(pending), 1);
    nxt();

    // 6: reset mid-drain
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(10 + i); wr_data = 8'(8'hAA + 8'h11 * i);
      mid(); nxt();
    end
    wr_valid = 1'b0; commit = 1'b1;
    mid(); nxt();
    commit = 1'b0;
    for (int i = 0; i < 2; i++) begin mid(); chk("t6_drain_we", 32'(mem_we), 1); nxt(); end
    rst_n = 1'b0; sync = 1'b0;
    mid(); chk("t6_rst_en", 32'(mem_en), 0); chk("t6_rst_pend", 32'(pending), 0);
    nxt(); nxt();
    exec_req = 1'b0; rst_n = 1'b1;
    nw = 0;
    for (int k = 0; k < 5; k++) begin mid(); if (mem_we) nw++; nxt(); end
    chk("t6_no_writes", 32'(nw), 0);
    mid(); chk("t6_ready", 32'(wr_ready), 1); chk("t6_pend", 32'(pending), 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
